// File: rtl/dragon_pkg.sv
// dragon_pkg: Dragon line states, op codes and the pure next-state functions
package dragon_pkg;

    localparam logic [2:0] NP = 3'b000;
    localparam logic [2:0] SC = 3'b001;
    localparam logic [2:0] M  = 3'b010;
    localparam logic [2:0] SM = 3'b011;
    localparam logic [2:0] E  = 3'b100;

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_EV = 2'b10;

    // Unused encodings 101..111 collapse to NP so they can never look owned.
    function automatic logic [2:0] norm_state(input logic [2:0] s);
        return (s > E) ? NP : s;
    endfunction

    // Requester state after its own op; reserved op 11 behaves as a read.
    function automatic logic [2:0] next_req_state(input logic [1:0] op, input logic [2:0] cur, input logic shared);
        logic [2:0] c;
        c = norm_state(cur);
        if (op == OP_EV) return NP;
        if (op == OP_WR) return (shared && c != M && c != E) ? SM : M;
        return (c != NP) ? c : (shared ? SC : E);
    endfunction

    // Peer state after snooping; BusRd is applied before BusUpd.
    function automatic logic [2:0] snoop_state(input logic [2:0] cur, input logic bus_rd, input logic bus_upd);
        logic [2:0] s;
        s = norm_state(cur);
        if (bus_rd) s = (s == E) ? SC : (s == M) ? SM : s;
        if (bus_upd) s = (s != NP) ? SC : s;
        return s;
    endfunction

endpackage

// File: rtl/dragon_rr_arbiter.sv
// dragon_rr_arbiter: round-robin one-hot grant starting at a rotating pointer
module dragon_rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] ptr;
    logic [W-1:0] k;

    // Scan from the farthest offset down so the first requester at/after ptr wins.
    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        k = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = W'((int'(ptr) + i) % N);
            if (req[k]) begin
                gnt = N'(1) << k;
                gnt_idx = k;
            end
        end
    end

    // Pointer moves just past the granted requester; holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else if (adv && |req) ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/dragon_snoop_cluster.sv
// dragon_snoop_cluster: N-cache Dragon update protocol on a serialised shared bus
module dragon_snoop_cluster import dragon_pkg::*; #(
    parameter int NUM_CACHES = 4,
    parameter int NUM_LINES = 16,
    parameter int IDX_W = $clog2(NUM_LINES),
    parameter int CNT_W = 16,
    localparam int CW = $clog2(NUM_CACHES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CACHES-1:0]       req_valid,
    input  logic [2*NUM_CACHES-1:0]     req_op,
    input  logic [IDX_W*NUM_CACHES-1:0] req_idx,
    output logic [NUM_CACHES-1:0]       req_ready,
    output logic [NUM_CACHES-1:0]       resp_valid,
    output logic                        resp_hit,
    output logic                        bus_rd,
    output logic                        bus_upd,
    output logic                        bus_flush,
    output logic                        bus_shared,
    input  logic [CW-1:0]               dbg_cache,
    input  logic [IDX_W-1:0]            dbg_idx,
    output logic [2:0]                  dbg_state,
    output logic [CNT_W-1:0]            cnt_rd,
    output logic [CNT_W-1:0]            cnt_upd,
    output logic [CNT_W-1:0]            cnt_flush
);

    logic [2:0] st [NUM_CACHES][NUM_LINES];
    logic [NUM_CACHES-1:0] gnt;
    logic [CW-1:0] gi;
    logic [1:0] op;
    logic [IDX_W-1:0] li;
    logic [2:0] cur, nxt;
    logic shared, accept, ev_rd, ev_upd, ev_flush;

    dragon_rr_arbiter #(.N(NUM_CACHES)) u_arb (
        .clk(clk),
        .rst(rst),
        .req(req_valid),
        .adv(accept),
        .gnt(gnt),
        .gnt_idx(gi)
    );

    assign req_ready = gnt;
    assign accept = |(req_valid & gnt);
    assign op = req_op[int'(gi)*2 +: 2];
    assign li = req_idx[int'(gi)*IDX_W +: IDX_W];
    assign cur = norm_state(st[gi][li]);
    assign nxt = next_req_state(op, cur, shared);
    assign ev_rd = accept && op != OP_EV && cur == NP;
    assign ev_upd = accept && op == OP_WR && shared && cur != M && cur != E;
    assign ev_flush = accept && op == OP_EV && (cur == M || cur == SM);
    assign dbg_state = (int'(dbg_cache) < NUM_CACHES) ? norm_state(st[dbg_cache][dbg_idx]) : NP;

    // Shared line: any peer holding the requested line, on pre-update state.
    always_comb begin
        shared = 1'b0;
        for (int p = 0; p < NUM_CACHES; p++)
            if (p != int'(gi) && norm_state(st[p][li]) != NP) shared = 1'b1;
    end

    // Requester takes its own next state; peers snoop the same line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CACHES; c++)
                for (int i = 0; i < NUM_LINES; i++)
                    st[c][i] <= NP;
        end else if (accept) begin
            for (int c = 0; c < NUM_CACHES; c++)
                st[c][li] <= (c == int'(gi)) ? nxt : snoop_state(st[c][li], ev_rd, ev_upd);
        end
    end

    // Response, bus event flags and saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= '0;
            resp_hit <= 1'b0;
            bus_rd <= 1'b0;
            bus_upd <= 1'b0;
            bus_flush <= 1'b0;
            bus_shared <= 1'b0;
            cnt_rd <= '0;
            cnt_upd <= '0;
            cnt_flush <= '0;
        end else begin
            resp_valid <= accept ? gnt : '0;
            if (accept) begin
                resp_hit <= cur != NP;
                bus_rd <= ev_rd;
                bus_upd <= ev_upd;
                bus_flush <= ev_flush;
                bus_shared <= shared;
            end
            if (ev_rd && !(&cnt_rd)) cnt_rd <= cnt_rd + 1'b1;
            if (ev_upd && !(&cnt_upd)) cnt_upd <= cnt_upd + 1'b1;
            if (ev_flush && !(&cnt_flush)) cnt_flush <= cnt_flush + 1'b1;
        end
    end

endmodule

// File: tb/tb_dragon_snoop_cluster.sv
// tb_dragon_snoop_cluster: scoreboard bench for the Dragon snooping cluster
module tb_dragon_snoop_cluster;

    localparam int NC = 4;
    localparam int NL = 16;
    localparam int IW = 4;
    localparam int CW = 2;
    localparam int CNT = 16;

    localparam logic [2:0] S_NP = 3'b000;
    localparam logic [2:0] S_SC = 3'b001;
    localparam logic [2:0] S_M  = 3'b010;
    localparam logic [2:0] S_SM = 3'b011;
    localparam logic [2:0] S_E  = 3'b100;

    typedef struct {
        int c;
        bit hit;
        bit rd;
        bit upd;
        bit flush;
        bit shared;
    } exp_t;

    logic clk, rst;
    logic [NC-1:0] req_valid, req_ready, resp_valid;
    logic [2*NC-1:0] req_op;
    logic [IW*NC-1:0] req_idx;
    logic resp_hit, bus_rd, bus_upd, bus_flush, bus_shared;
    logic [CW-1:0] dbg_cache;
    logic [IW-1:0] dbg_idx;
    logic [2:0] dbg_state;
    logic [CNT-1:0] cnt_rd, cnt_upd, cnt_flush;

    exp_t q[$];
    int asserts = 0;
    int fails = 0;
    bit mon_en = 1'b1;

    dragon_snoop_cluster #(.NUM_CACHES(NC), .NUM_LINES(NL), .CNT_W(CNT)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_op(req_op),
        .req_idx(req_idx),
        .req_ready(req_ready),
        .resp_valid(resp_valid),
        .resp_hit(resp_hit),
        .bus_rd(bus_rd),
        .bus_upd(bus_upd),
        .bus_flush(bus_flush),
        .bus_shared(bus_shared),
        .dbg_cache(dbg_cache),
        .dbg_idx(dbg_idx),
        .dbg_state(dbg_state),
        .cnt_rd(cnt_rd),
        .cnt_upd(cnt_upd),
        .cnt_flush(cnt_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every response pops the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst && resp_valid != '0) begin
            asserts++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_resp: resp_valid=%b with empty scoreboard", resp_valid);
            end else begin
                e = q.pop_front();
                asserts++;
                if (resp_valid !== NC'(1) << e.c) begin
                    fails++;
                    $display("FAIL resp_valid: got %b want %b", resp_valid, NC'(1) << e.c);
                end
                asserts++;
                if ({resp_hit, bus_rd, bus_upd, bus_flush, bus_shared} !== {e.hit, e.rd, e.upd, e.flush, e.shared}) begin
                    fails++;
                    $display("FAIL resp_flags cache%0d: got hit/rd/upd/flush/shared=%b want %b", e.c,
                             {resp_hit, bus_rd, bus_upd, bus_flush, bus_shared}, {e.hit, e.rd, e.upd, e.flush, e.shared});
                end
            end
        end
    end

    task automatic peek(input int c, input int i, output logic [2:0] s);
        dbg_cache = CW'(c);
        dbg_idx = IW'(i);
        #1;
        s = dbg_state;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single request from one cache; expectation pushed as it is driven.
    task automatic issue(input int c, input logic [1:0] op, input int idx, input exp_t e);
        int n;
        @(negedge clk);
        req_valid = '0;
        req_valid[c] = 1'b1;
        req_op[c*2 +: 2] = op;
        req_idx[c*IW +: IW] = IW'(idx);
        q.push_back(e);
        #1;
        n = 0;
        while (!req_ready[c] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        asserts++;
        if (n >= 20) begin
            fails++;
            $display("FAIL grant_timeout cache%0d: ready=%b want bit %0d", c, req_ready, c);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[c] = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] s;
        rst = 1'b1;
        req_valid = '0;
        req_op = '0;
        req_idx = '0;
        dbg_cache = '0;
        dbg_idx = '0;
        repeat (2) @(negedge clk);
        asserts++;
        if ({resp_valid, resp_hit, bus_rd, bus_upd, bus_flush, bus_shared} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 0", {resp_valid, resp_hit, bus_rd, bus_upd, bus_flush, bus_shared});
        end
        asserts++;
        if ({cnt_rd, cnt_upd, cnt_flush} !== '0) begin
            fails++;
            $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", cnt_rd, cnt_upd, cnt_flush);
        end
        peek(0, 3, s);
        asserts++;
        if (s !== S_NP) begin
            fails++;
            $display("FAIL reset_state: got %b want %b", s, S_NP);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_miss();
        logic [2:0] s;
        issue(0, 2'b00, 3, '{c: 0, hit: 0, rd: 1, upd: 0, flush: 0, shared: 0});
        peek(0, 3, s);
        asserts++;
        if (s !== S_E) begin
            fails++;
            $display("FAIL read_miss_state: got %b want %b", s, S_E);
        end
        asserts++;
        if (cnt_rd !== 16'd1) begin
            fails++;
            $display("FAIL read_miss_cnt_rd: got %0d want 1", cnt_rd);
        end
    endtask

    task automatic test_write_then_read();
        logic [2:0] s;
        issue(0, 2'b01, 3, '{c: 0, hit: 1, rd: 0, upd: 0, flush: 0, shared: 0});
        peek(0, 3, s);
        asserts++;
        if (s !== S_M) begin
            fails++;
            $display("FAIL write_e_state: got %b want %b", s, S_M);
        end
        issue(1, 2'b00, 3, '{c: 1, hit: 0, rd: 1, upd: 0, flush: 0, shared: 1});
        peek(0, 3, s);
        asserts++;
        if (s !== S_SM) begin
            fails++;
            $display("FAIL snoop_rd_m_state: got %b want %b", s, S_SM);
        end
        peek(1, 3, s);
        asserts++;
        if (s !== S_SC) begin
            fails++;
            $display("FAIL shared_read_state: got %b want %b", s, S_SC);
        end
        asserts++;
        if (cnt_rd !== 16'd2) begin
            fails++;
            $display("FAIL cnt_rd_after_share: got %0d want 2", cnt_rd);
        end
    endtask

    task automatic test_update();
        logic [2:0] s;
        issue(1, 2'b01, 3, '{c: 1, hit: 1, rd: 0, upd: 1, flush: 0, shared: 1});
        peek(1, 3, s);
        asserts++;
        if (s !== S_SM) begin
            fails++;
            $display("FAIL update_req_state: got %b want %b", s, S_SM);
        end
        peek(0, 3, s);
        asserts++;
        if (s !== S_SC) begin
            fails++;
            $display("FAIL update_peer_state: got %b want %b", s, S_SC);
        end
        asserts++;
        if (cnt_upd !== 16'd1) begin
            fails++;
            $display("FAIL cnt_upd: got %0d want 1", cnt_upd);
        end
    endtask

    task automatic test_evict();
        logic [2:0] s;
        issue(0, 2'b10, 3, '{c: 0, hit: 1, rd: 0, upd: 0, flush: 0, shared: 1});
        peek(0, 3, s);
        asserts++;
        if (s !== S_NP) begin
            fails++;
            $display("FAIL evict_sc_state: got %b want %b", s, S_NP);
        end
        issue(1, 2'b01, 3, '{c: 1, hit: 1, rd: 0, upd: 0, flush: 0, shared: 0});
        peek(1, 3, s);
        asserts++;
        if (s !== S_M) begin
            fails++;
            $display("FAIL write_sm_alone_state: got %b want %b", s, S_M);
        end
        issue(1, 2'b10, 3, '{c: 1, hit: 1, rd: 0, upd: 0, flush: 1, shared: 0});
        issue(1, 2'b10, 3, '{c: 1, hit: 0, rd: 0, upd: 0, flush: 0, shared: 0});
        peek(1, 3, s);
        asserts++;
        if (s !== S_NP) begin
            fails++;
            $display("FAIL evict_m_state: got %b want %b", s, S_NP);
        end
        asserts++;
        if (cnt_flush !== 16'd1) begin
            fails++;
            $display("FAIL cnt_flush: got %0d want 1", cnt_flush);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 8; k++)
            q.push_back('{c: k % NC, hit: k >= NC, rd: k < NC, upd: 0, flush: 0, shared: k != 0});
        @(negedge clk);
        req_op = '0;
        req_idx = {NC{4'd7}};
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            asserts++;
            if (!$onehot(resp_valid)) begin
                fails++;
                $display("FAIL rr_onehot cycle%0d: got %b want one-hot", k, resp_valid);
            end
        end
        req_valid = '0;
        @(negedge clk);
        asserts++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL rr_drained: got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_write_miss_and_reset();
        logic [2:0] s;
        issue(0, 2'b00, 5, '{c: 0, hit: 0, rd: 1, upd: 0, flush: 0, shared: 0});
        issue(2, 2'b01, 5, '{c: 2, hit: 0, rd: 1, upd: 1, flush: 0, shared: 1});
        peek(2, 5, s);
        asserts++;
        if (s !== S_SM) begin
            fails++;
            $display("FAIL write_miss_req_state: got %b want %b", s, S_SM);
        end
        peek(0, 5, s);
        asserts++;
        if (s !== S_SC) begin
            fails++;
            $display("FAIL write_miss_peer_state: got %b want %b", s, S_SC);
        end
        mon_en = 1'b0;
        @(negedge clk);
        req_op = '0;
        req_idx = {NC{4'd9}};
        req_valid = '1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        asserts++;
        if (resp_valid !== '0 || {cnt_rd, cnt_upd, cnt_flush} !== '0) begin
            fails++;
            $display("FAIL midburst_reset_regs: resp=%b cnt=%0d/%0d/%0d want 0", resp_valid, cnt_rd, cnt_upd, cnt_flush);
        end
        for (int c = 0; c < NC; c++) begin
            peek(c, 5, s);
            asserts++;
            if (s !== S_NP) begin
                fails++;
                $display("FAIL midburst_reset_idx5 cache%0d: got %b want %b", c, s, S_NP);
            end
            peek(c, 9, s);
            asserts++;
            if (s !== S_NP) begin
                fails++;
                $display("FAIL midburst_reset_idx9 cache%0d: got %b want %b", c, s, S_NP);
            end
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        mon_en = 1'b1;
        issue(1, 2'b00, 9, '{c: 1, hit: 0, rd: 1, upd: 0, flush: 0, shared: 0});
        asserts++;
        if (cnt_rd !== 16'd1) begin
            fails++;
            $display("FAIL post_reset_cnt_rd: got %0d want 1", cnt_rd);
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_then_read();
        test_update();
        test_evict();
        test_back_to_back();
        test_write_miss_and_reset();
        repeat (2) @(negedge clk);
        asserts++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover: got %0d pending want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dragon_snoop_cluster.md
Name: dragon_snoop_cluster

Overview:
- Parametrised Dragon update-protocol cluster: NUM_CACHES snooping caches, each with a NUM_LINES line-state table, on one shared, serialised bus.
- Supersedes the fixed two-cache, single-line Dragon controller/datapath pair.
- Adds the following:
  - round-robin bus arbitration;
  - a real shared-line computed from peer state;
  - eviction with flush;
  - per-line tracking;
  - bus event counters.
- Sits between the CPU-side request ports and the memory bus model.

Parameters:
- NUM_CACHES, 4, number of caches on the bus (2..8).
- NUM_LINES, 16, lines tracked per cache (power of 2, ≥2).
- IDX_W, $clog2(NUM_LINES), line index width (derived).
- CNT_W, 16, event counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_CACHES  per-cache request pending.
- req_op  in  2*NUM_CACHES  per-cache op: 00 read, 01 write, 10 evict, 11 reserved (treated as read).
- req_idx  in  IDX_W*NUM_CACHES  per-cache line index.
- req_ready  out  NUM_CACHES  one-hot grant, combinational from req_valid and the arbiter pointer.
- resp_valid  out  NUM_CACHES  one-hot, registered, high one cycle after acceptance.
- resp_hit  out  1  registered: the accepted line was not NP before the op.
- bus_rd  out  1  registered: the last transaction issued BusRd.
- bus_upd  out  1  registered: the last transaction issued BusUpd.
- bus_flush  out  1  registered: the last transaction wrote back a dirty line.
- bus_shared  out  1  registered: shared-line value sampled for the last transaction.
- dbg_cache  in  $clog2(NUM_CACHES)  debug read select.
- dbg_idx  in  IDX_W  debug read line.
- dbg_state  out  3  combinational state of (dbg_cache, dbg_idx).
- cnt_rd  out  CNT_W  saturating BusRd count.
- cnt_upd  out  CNT_W  saturating BusUpd count.
- cnt_flush  out  CNT_W  saturating flush count.

Behaviour:
- State encoding: NP=000, SC=001, M=010, SM=011, E=100. Encodings 101..111 read as NP.
- Reset values:
  - all lines NP;
  - arbiter pointer = 0;
  - resp_valid, resp_hit, bus_rd, bus_upd, bus_flush, bus_shared = 0;
  - counters = 0.
- Arbitration:
  - one transaction per cycle;
  - grant goes to the first valid cache at or after the pointer (wrapping);
  - accepted = req_valid & req_ready at a clock edge;
  - on acceptance, pointer = granted + 1, mod NUM_CACHES;
  - no valid request: pointer holds, no grant.
- Requester holds valid/op/idx stable until granted.
- Latency: the state update and all registered outputs take effect at the accepting edge, so resp_valid appears in the following cycle.
- shared = OR over peers p≠requester of (state[p][idx] != NP), evaluated on pre-update state.
- Requester transitions:
  - Read, state≠NP: no bus op, state unchanged, hit=1.
  - Read, NP: BusRd; next state SC if shared, else E.
  - Write, M: stays M. Write, E: goes to M. No bus op in either case.
  - Write, SC or SM: BusUpd if shared (next state SM); otherwise no bus op (next state M).
  - Write, NP: BusRd; additionally BusUpd if shared. Next state SM if shared, else M.
  - Evict: next state NP. If the prior state is M or SM, bus_flush=1. Evicting NP is a no-op with hit=0.
- Peer snoop (same idx, peers only):
  - On BusRd: E→SC, M→SM, SC and SM unchanged.
  - On BusUpd: SM→SC, M→SC, E→SC, SC unchanged.
  - Write-miss with BusRd+BusUpd: BusRd is applied then BusUpd, so the net result is M/E/SM→SC.
- Counters:
  - increment by 1 per transaction with the respective event;
  - saturate at all-ones.
- Invariant, must hold after every edge, per idx:
  - at most one cache in {M, E, SM};
  - if any cache is in M or E, all peers are NP.
- Reset mid-operation: the in-flight acceptance is discarded and the requester reasserts after rst falls.

Decomposition:
- dragon_pkg holds:
  - state localparams NP/SC/M/SM/E;
  - op codes OP_RD/OP_WR/OP_EV;
  - a pure function next_req_state(op, cur, shared) and a pure function snoop_state(cur, bus_rd, bus_upd).
- Sub-module dragon_rr_arbiter: parameter N; inputs req[N] and adv; outputs one-hot gnt and gnt_idx; owns the pointer register.

Test Plan:
- Reset, then cache0 reads idx 3 → resp_hit=0, bus_rd=1, bus_shared=0. dbg(0,3)=100 (E). cnt_rd=1.
- Cache0 writes idx 3, then cache1 reads idx 3 →
  - the write: cache0 goes to M with no bus op;
  - the read: bus_rd=1, bus_shared=1, cache0 goes to SM (011), cache1 goes to SC (001).
- Cache1 writes idx 3 from the previous state → bus_upd=1, bus_shared=1, cache1 goes to SM, cache0 goes to SC. cnt_upd=1.
- Cache0 evicts, then cache1 writes idx 3 →
  - eviction: cache0 goes to NP, bus_flush=0;
  - write: bus_shared=0, cache1 goes to M with no BusUpd.
  - Then cache1 evicts → bus_flush=1.
- All four caches assert valid in the same cycle for 8 cycles → grant order 0,1,2,3,0,1,2,3, exactly one resp_valid per cycle.
- Cache2 write-misses idx 5 while cache0 is in E → bus_rd=1, bus_upd=1, cache2 goes to SM, cache0 goes to SC. Then assert rst mid-burst → all states NP, counters 0.
